// File: rtl/fifo_unpack_drain_pkg.sv
// Shared constants and width helper for the FIFO unpack/drain stage and its FIFO wrapper.
package fifo_unpack_drain_pkg;

  localparam int DEF_IN_WIDTH = 32'sd32;
  localparam int DEF_RATIO    = 32'sd4;

  // Counter width that never collapses to zero bits (RATIO=1 still needs a 1-bit index).
  function automatic int clog2_min1(input int value);
    int bits_v;
    bits_v = $clog2(value);
    if (bits_v < 32'sd1) begin
      return 32'sd1;
    end else begin
      return bits_v;
    end
  endfunction

endpackage

// File: rtl/fifo_unpack_drain.sv
// Pops wide FIFO words and streams them out as RATIO narrow beats, LS slice first.
// Optional macro FIFO_UNPACK_FLUSH_EN adds a synchronous flush input.
module fifo_unpack_drain
  import fifo_unpack_drain_pkg::*;
#(
  parameter int IN_WIDTH  = DEF_IN_WIDTH,
  parameter int RATIO     = DEF_RATIO,
  localparam int OUT_WIDTH = IN_WIDTH / RATIO
) (
  input  logic                 clk,
  input  logic                 reset,
`ifdef FIFO_UNPACK_FLUSH_EN
  input  logic                 flush,
`endif
  input  logic [IN_WIDTH-1:0]  fifo_rddata,
  input  logic                 fifo_empty,
  output logic                 fifo_read,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [OUT_WIDTH-1:0] m_data,
  output logic                 m_last
);

  localparam int CNT_W = clog2_min1(RATIO);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(RATIO - 1);

  logic [IN_WIDTH-1:0]  hold_r;
  logic                 hold_valid_r;
  logic [CNT_W-1:0]     beat_cnt_r;

  logic                 flush_s;
  logic                 accept_s;
  logic                 last_s;
  logic                 last_acc_s;
  logic                 fifo_read_s;
  logic [OUT_WIDTH-1:0] m_data_s;

`ifdef FIFO_UNPACK_FLUSH_EN
  assign flush_s = flush;
`else
  assign flush_s = 1'b0;
`endif

  // Handshake decode and pop request; the pop doubles as prefetch on the last accepted beat.
  always_comb begin
    accept_s    = hold_valid_r & m_ready;
    last_s      = hold_valid_r & (beat_cnt_r == LAST_IDX);
    last_acc_s  = accept_s & last_s;
    fifo_read_s = reset & ~fifo_empty & (~hold_valid_r | last_acc_s) & ~flush_s;
  end

  // Slice select for the current beat.
  always_comb begin
    m_data_s = {OUT_WIDTH{1'b0}};
    for (int i = 0; i < RATIO; i++) begin
      if (beat_cnt_r == CNT_W'(i)) begin
        m_data_s = hold_r[i*OUT_WIDTH +: OUT_WIDTH];
      end else begin
        m_data_s = m_data_s;
      end
    end
  end

  // Word holding register and beat index; a pop wins over the last-beat clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_r       <= {IN_WIDTH{1'b0}};
      hold_valid_r <= 1'b0;
      beat_cnt_r   <= {CNT_W{1'b0}};
    end else if (flush_s) begin
      hold_valid_r <= 1'b0;
      beat_cnt_r   <= {CNT_W{1'b0}};
    end else if (fifo_read_s) begin
      hold_r       <= fifo_rddata;
      hold_valid_r <= 1'b1;
      beat_cnt_r   <= {CNT_W{1'b0}};
    end else if (last_acc_s) begin
      hold_valid_r <= 1'b0;
      beat_cnt_r   <= {CNT_W{1'b0}};
    end else if (accept_s) begin
      beat_cnt_r   <= beat_cnt_r + CNT_W'(1);
    end else begin
      beat_cnt_r   <= beat_cnt_r;
    end
  end

  assign fifo_read = fifo_read_s;
  assign m_valid   = hold_valid_r;
  assign m_data    = m_data_s;
  assign m_last    = last_s;

endmodule

// File: tb/tb_fifo_unpack_drain.sv
// Directed self-checking bench for fifo_unpack_drain (IN_WIDTH=32, RATIO=4) fed by a queue-model FIFO.
module tb_fifo_unpack_drain;

  logic        clk;
  logic        reset;
  logic [31:0] fifo_rddata;
  logic        fifo_empty;
  logic        fifo_read;
  logic        m_valid;
  logic        m_ready;
  logic [7:0]  m_data;
  logic        m_last;
`ifdef FIFO_UNPACK_FLUSH_EN
  logic        flush;
`endif

  int total;
  int bad;

  logic [31:0] mem [0:31];
  int wr_ptr;
  int rd_ptr;

  fifo_unpack_drain #(.IN_WIDTH(32), .RATIO(4)) dut (
    .clk        (clk),
    .reset      (reset),
`ifdef FIFO_UNPACK_FLUSH_EN
    .flush      (flush),
`endif
    .fifo_rddata(fifo_rddata),
    .fifo_empty (fifo_empty),
    .fifo_read  (fifo_read),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_last     (m_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign fifo_empty  = (rd_ptr == wr_ptr);
  assign fifo_rddata = mem[rd_ptr[4:0]];

  always @(posedge clk) begin
    if (fifo_read) rd_ptr <= rd_ptr + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] w);
    mem[wr_ptr[4:0]] = w;
    wr_ptr = wr_ptr + 1;
  endtask

  // Expects slice 0 of w on display now, ready held high; consumes 4 beats.
  task automatic drain4(input string tag, input logic [31:0] w);
    for (int k = 0; k < 4; k++) begin
      chk({tag, "_valid"}, {31'd0, m_valid}, 32'd1);
      chk({tag, "_data"},  {24'd0, m_data}, {24'd0, w[k*8 +: 8]});
      chk({tag, "_last"},  {31'd0, m_last}, (k == 3) ? 32'd1 : 32'd0);
      tick();
    end
  endtask

  initial begin
    int base;
    int idx;
    logic       stall_v;
    logic [7:0] stall_d;
    total = 0; bad = 0; wr_ptr = 0; rd_ptr = 0;
    reset = 1'b0; m_ready = 1'b1;
`ifdef FIFO_UNPACK_FLUSH_EN
    flush = 1'b0;
`endif

    // Reset with a non-empty FIFO, then release and single word at full throughput
    push(32'hDDCCBBAA);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_read",  {31'd0, fifo_read}, 32'd0);
    chk("rst_valid", {31'd0, m_valid}, 32'd0);
    chk("rst_data",  {24'd0, m_data}, 32'd0);
    chk("rst_last",  {31'd0, m_last}, 32'd0);
    reset = 1'b1;
    #1;
    chk("rel_read",  {31'd0, fifo_read}, 32'd1);
    chk("rel_valid", {31'd0, m_valid}, 32'd0);
    tick();
    chk("first_read", {31'd0, fifo_read}, 32'd0);
    drain4("single", 32'hDDCCBBAA);
    chk("single_idle", {31'd0, m_valid}, 32'd0);
    chk("single_pops", rd_ptr, 32'd1);

    // Back-to-back words: prefetch coincides with 0x44 acceptance
    push(32'h44332211);
    push(32'h88776655);
    #1;
    chk("b2b_read0", {31'd0, fifo_read}, 32'd1);
    tick();
    for (int k = 0; k < 8; k++) begin
      chk("b2b_valid", {31'd0, m_valid}, 32'd1);
      chk("b2b_data",  {24'd0, m_data}, 32'((k + 1) * 17));
      chk("b2b_last",  {31'd0, m_last}, (k % 4 == 3) ? 32'd1 : 32'd0);
      chk("b2b_read",  {31'd0, fifo_read}, (k == 3) ? 32'd1 : 32'd0);
      tick();
    end
    chk("b2b_idle", {31'd0, m_valid}, 32'd0);
    chk("b2b_pops", rd_ptr, 32'd3);

    // Backpressure with ready pattern 1,0,0 repeating
    base = rd_ptr;
    push(32'h04030201);
    push(32'h08070605);
    idx = 0;
    stall_v = 1'b0;
    stall_d = 8'h00;
    for (int cyc = 0; cyc < 60; cyc++) begin
      m_ready = (cyc % 3 == 0);
      #1;
      if (stall_v) begin
        chk("bp_stall_data", {24'd0, m_data}, {24'd0, stall_d});
        stall_v = 1'b0;
      end
      if (fifo_read && m_valid) chk("bp_pop_on_last", {31'd0, m_last & m_ready}, 32'd1);
      if (m_valid && m_ready) begin
        chk("bp_data", {24'd0, m_data}, 32'(idx + 1));
        chk("bp_last", {31'd0, m_last}, (idx % 4 == 3) ? 32'd1 : 32'd0);
        idx++;
      end else if (m_valid) begin
        stall_v = 1'b1;
        stall_d = m_data;
      end else begin
        stall_v = 1'b0;
      end
      tick();
      if (idx == 8) break;
    end
    chk("bp_beats", idx, 32'd8);
    chk("bp_pops", rd_ptr - base, 32'd2);
    m_ready = 1'b1;
    #1;
    chk("bp_idle", {31'd0, m_valid}, 32'd0);

    // Empty boundary: one word, 3-cycle gap, next word at slice 0
    push(32'h0D0C0B0A);
    tick();
    drain4("gap_w0", 32'h0D0C0B0A);
    for (int g = 0; g < 3; g++) begin
      chk("gap_valid", {31'd0, m_valid}, 32'd0);
      chk("gap_read",  {31'd0, fifo_read}, 32'd0);
      tick();
    end
    push(32'h14131211);
    #1;
    chk("gap_resume_read", {31'd0, fifo_read}, 32'd1);
    tick();
    drain4("gap_w1", 32'h14131211);
    chk("gap_pops", rd_ptr, 32'd7);

    // Reset mid-word after two accepted beats
    push(32'hDDCCBBAA);
    tick();
    tick();
    tick();
    chk("mid_pre_data", {24'd0, m_data}, 32'h000000CC);
    reset = 1'b0;
    #1;
    chk("mid_valid", {31'd0, m_valid}, 32'd0);
    chk("mid_data",  {24'd0, m_data}, 32'd0);
    chk("mid_last",  {31'd0, m_last}, 32'd0);
    push(32'h99887766);
    #1;
    chk("mid_read", {31'd0, fifo_read}, 32'd0);
    tick();
    chk("mid_read2", {31'd0, fifo_read}, 32'd0);
    reset = 1'b1;
    #1;
    chk("mid_rel_read", {31'd0, fifo_read}, 32'd1);
    tick();
    drain4("mid_next", 32'h99887766);
    chk("mid_pops", rd_ptr, 32'd9);

`ifdef FIFO_UNPACK_FLUSH_EN
    // Flush after the 0xAA beat drops the rest of the word
    push(32'hDDCCBBAA);
    push(32'h44332211);
    tick();
    chk("fl_aa", {24'd0, m_data}, 32'h000000AA);
    tick();
    flush = 1'b1;
    m_ready = 1'b0;
    #1;
    chk("fl_read",  {31'd0, fifo_read}, 32'd0);
    chk("fl_valid", {31'd0, m_valid}, 32'd1);
    tick();
    flush = 1'b0;
    m_ready = 1'b1;
    #1;
    chk("fl_after_valid", {31'd0, m_valid}, 32'd0);
    chk("fl_after_read",  {31'd0, fifo_read}, 32'd1);
    tick();
    drain4("fl_next", 32'h44332211);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
